// File: rtl/instruction_mem_access.sv
// Memory-access pipeline stage: issues data-cache requests, aligns store data, extends load data.
// Latency: request is combinational from EX/MEM; MEM/WB results register one cycle after completion.
// Backpressure: MA_stall holds EX/MEM until dmem_resp; IF_stall freezes the stage and parks a finished access in HOLD.

package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_opcode opcode;
    logic        load_regfile;
    logic [4:0]  rd;
    logic [2:0]  regfilemux_sel;
  } rv32i_control_word;

endpackage

module instruction_mem_access
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  rv32i_control_word ctrl_word_in,
  input  logic [31:0]       instruction_in,
  input  logic [31:0]       PC_in,
  input  logic [31:0]       alu_out_in,
  input  logic [31:0]       rs2_in,
  input  logic [3:0]        mem_byte_enable_in,
  input  logic              br_en_in,
  input  logic              IF_stall,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [31:0]       dmem_address,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_byte_enable,
  output logic              MA_stall,
  output rv32i_control_word ctrl_word_out,
  output logic [31:0]       instruction_out,
  output logic [31:0]       PC_out,
  output logic [31:0]       alu_out_out,
  output logic [31:0]       load_data_out,
  output logic              br_en_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        is_load, is_store, is_mem;
  logic        resp_taken;
  logic        adv;
  logic [4:0]  byte_shift;
  logic [31:0] capture_q;
  logic [31:0] load_src;
  logic [31:0] load_shifted;
  logic [31:0] load_ext;
  logic [2:0]  funct3;

  assign is_load    = (ctrl_word_in.opcode == op_load);
  assign is_store   = (ctrl_word_in.opcode == op_store);
  assign is_mem     = is_load || is_store;
  assign byte_shift = {alu_out_in[1:0], 3'b000};
  assign funct3     = instruction_in[14:12];

  // Request side: word-aligned address, store data lane-shifted to its byte offset.
  assign dmem_address     = {alu_out_in[31:2], 2'b00};
  assign dmem_wdata       = rs2_in << byte_shift;
  assign dmem_byte_enable = is_store ? mem_byte_enable_in : 4'b1111;

  assign adv = !MA_stall && !IF_stall;

  // Next-state, request strobes and stall; reset silences all strobes immediately.
  always_comb begin
    state_next = state;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    MA_stall   = 1'b0;
    resp_taken = 1'b0;
    if (rst) begin
      case (state)
        IDLE, WAIT: begin
          if (is_mem) begin
            dmem_read  = is_load;
            dmem_write = is_store;
            if (dmem_resp) begin
              resp_taken = 1'b1;
              // A finished access that cannot advance is parked so it is never re-issued.
              state_next = IF_stall ? HOLD : IDLE;
            end else begin
              MA_stall   = 1'b1;
              state_next = WAIT;
            end
          end else begin
            state_next = IDLE;
          end
        end
        HOLD: begin
          if (!IF_stall) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Keep the returned word while the pipeline is frozen, since the cache drives it for one cycle only.
  always_ff @(posedge clk) begin
    if (!rst)                         capture_q <= 32'h0;
    else if (resp_taken && IF_stall)  capture_q <= dmem_rdata;
  end

  // Load extraction: pick the addressed bytes and extend according to funct3.
  always_comb begin
    load_src     = (state == HOLD) ? capture_q : dmem_rdata;
    load_shifted = load_src >> byte_shift;
    case (funct3)
      3'b000:  load_ext = {{24{load_shifted[7]}},  load_shifted[7:0]};
      3'b100:  load_ext = {24'h0,                  load_shifted[7:0]};
      3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b101:  load_ext = {16'h0,                  load_shifted[15:0]};
      default: load_ext = load_shifted;
    endcase
  end

  // MEM/WB register: advances only when neither this stage nor fetch is stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_word_out   <= '0;
      instruction_out <= 32'h0;
      PC_out          <= 32'h0;
      alu_out_out     <= 32'h0;
      load_data_out   <= 32'h0;
      br_en_out       <= 1'b0;
    end else if (adv) begin
      ctrl_word_out   <= ctrl_word_in;
      instruction_out <= instruction_in;
      PC_out          <= PC_in;
      alu_out_out     <= alu_out_in;
      load_data_out   <= is_load ? load_ext : 32'h0;
      br_en_out       <= br_en_in;
    end
  end

endmodule

// File: tb/tb_instruction_mem_access.sv
module tb_instruction_mem_access;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst;
  rv32i_control_word ctrl_word_in;
  logic [31:0]       instruction_in, PC_in, alu_out_in, rs2_in;
  logic [3:0]        mem_byte_enable_in;
  logic              br_en_in, IF_stall;
  logic [31:0]       dmem_rdata;
  logic              dmem_resp;
  logic              dmem_read, dmem_write;
  logic [31:0]       dmem_address, dmem_wdata;
  logic [3:0]        dmem_byte_enable;
  logic              MA_stall;
  rv32i_control_word ctrl_word_out;
  logic [31:0]       instruction_out, PC_out, alu_out_out, load_data_out;
  logic              br_en_out;

  always #5 clk = ~clk;

  instruction_mem_access dut (
    .clk(clk), .rst(rst),
    .ctrl_word_in(ctrl_word_in), .instruction_in(instruction_in), .PC_in(PC_in),
    .alu_out_in(alu_out_in), .rs2_in(rs2_in), .mem_byte_enable_in(mem_byte_enable_in),
    .br_en_in(br_en_in), .IF_stall(IF_stall), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable), .MA_stall(MA_stall),
    .ctrl_word_out(ctrl_word_out), .instruction_out(instruction_out), .PC_out(PC_out),
    .alu_out_out(alu_out_out), .load_data_out(load_data_out), .br_en_out(br_en_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [31:0] w, input logic [1:0] off);
    logic [31:0] t;
    t = w >> (32'(off) * 8);
    case (f3)
      3'd0:    return {{24{t[7]}}, t[7:0]};
      3'd4:    return {24'h0, t[7:0]};
      3'd1:    return {{16{t[15]}}, t[15:0]};
      3'd5:    return {16'h0, t[15:0]};
      default: return t;
    endcase
  endfunction

  // ---------------- reference model (transaction level) ----------------
  // m_done: the op currently presented has already received its response.
  logic              m_done = 1'b0;
  logic [31:0]       m_got;
  rv32i_control_word e_ctrl;
  logic [31:0]       e_instr, e_pc, e_alu, e_load;
  logic              e_br;

  always @(posedge clk) begin
    logic ism, stall_now, adv_now;
    if (!rst) begin
      m_done = 1'b0;
      e_ctrl = '0; e_instr = 0; e_pc = 0; e_alu = 0; e_load = 0; e_br = 0;
    end else begin
      ism       = (ctrl_word_in.opcode == op_load) || (ctrl_word_in.opcode == op_store);
      stall_now = ism && !m_done && !dmem_resp;
      adv_now   = !stall_now && !IF_stall;
      if (adv_now) begin
        e_ctrl  = ctrl_word_in;
        e_instr = instruction_in;
        e_pc    = PC_in;
        e_alu   = alu_out_in;
        e_br    = br_en_in;
        e_load  = (ctrl_word_in.opcode == op_load)
                  ? extract(instruction_in[14:12], m_done ? m_got : dmem_rdata, alu_out_in[1:0]) : 32'h0;
        m_done  = 1'b0;
      end else if (ism && !m_done && dmem_resp) begin
        m_done = 1'b1;
        m_got  = dmem_rdata;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit run_cmp = 0;
  always @(negedge clk) begin
    logic isl, iss, er, ew, es;
    if (run_cmp) begin
      isl = (ctrl_word_in.opcode == op_load);
      iss = (ctrl_word_in.opcode == op_store);
      er  = rst && isl && !m_done;
      ew  = rst && iss && !m_done;
      es  = rst && (isl || iss) && !m_done && !dmem_resp;
      chk("dmem_read", dmem_read, er);
      chk("dmem_write", dmem_write, ew);
      chk("ma_stall", MA_stall, es);
      if (er || ew) chk("dmem_address", dmem_address, {alu_out_in[31:2], 2'b00});
      if (ew) begin
        chk("dmem_wdata", dmem_wdata, rs2_in << (32'(alu_out_in[1:0]) * 8));
        chk("dmem_be_store", dmem_byte_enable, mem_byte_enable_in);
      end
      if (er) chk("dmem_be_load", dmem_byte_enable, 4'hF);
      chk("ctrl_word_out", 32'(ctrl_word_out), 32'(e_ctrl));
      chk("instruction_out", instruction_out, e_instr);
      chk("pc_out", PC_out, e_pc);
      chk("alu_out_out", alu_out_out, e_alu);
      chk("load_data_out", load_data_out, e_load);
      chk("br_en_out", br_en_out, e_br);
    end
  end

  // ---------------- cache memory and stimulus ----------------
  logic [31:0] mem [0:255];

  task automatic drive_bubble();
    ctrl_word_in = '0; instruction_in = 0; PC_in = 0; alu_out_in = 0; rs2_in = 0;
    mem_byte_enable_in = 0; br_en_in = 0; IF_stall = 0; dmem_resp = 0; dmem_rdata = 0;
  endtask

  // Presents one op, answers it after lat cycles, applies IF_stall (st_start<0 means random),
  // and returns just after the edge on which the op advanced.
  task automatic do_op(input rv32i_opcode opc, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [3:0] be, input int lat,
                       input int st_start, input int st_len,
                       output int n_stall, output int n_req, output int n_req_done,
                       output logic [31:0] seen_addr, output logic [31:0] seen_wdata,
                       output logic [3:0] seen_be);
    rv32i_control_word cw;
    logic [31:0] ins, aligned;
    logic ism, done, resp, advd, adv;
    n_stall = 0; n_req = 0; n_req_done = 0;
    seen_addr = 0; seen_wdata = 0; seen_be = 0;
    cw.opcode = opc; cw.load_regfile = 1'($urandom); cw.rd = 5'($urandom);
    cw.regfilemux_sel = 3'($urandom);
    ins = $urandom; ins[14:12] = f3;
    ctrl_word_in = cw; instruction_in = ins; PC_in = $urandom; alu_out_in = addr;
    rs2_in = rs2; mem_byte_enable_in = be; br_en_in = 1'($urandom);
    aligned = rs2 << (32'(addr[1:0]) * 8);
    ism = (opc == op_load) || (opc == op_store);
    done = 0; advd = 0;
    for (int c = 0; c < 60; c++) begin
      if (st_start < 0) IF_stall = ($urandom_range(0, 3) == 0);
      else              IF_stall = (c >= st_start) && (c < st_start + st_len);
      resp = ism && !done && (c >= lat);
      dmem_resp  = resp;
      dmem_rdata = resp ? mem[addr[9:2]] : $urandom;
      #1;
      if (MA_stall) n_stall++;
      if (dmem_read || dmem_write) begin
        n_req++;
        if (done) n_req_done++;
        seen_addr = dmem_address; seen_wdata = dmem_wdata; seen_be = dmem_byte_enable;
      end
      @(posedge clk);
      adv = !IF_stall && !(ism && !done && !resp);
      if (resp) begin
        done = 1;
        if (opc == op_store)
          for (int b = 0; b < 4; b++)
            if (be[b]) mem[addr[9:2]][8*b +: 8] = aligned[8*b +: 8];
      end
      if (adv) begin advd = 1; break; end
      #1;
    end
    if (!advd) begin
      checks++; errors++;
      $display("FAIL op_timeout: op %h never advanced", opc);
    end
    #1;
    drive_bubble();
    #1;
  endtask

  initial begin
    int ns, nr, nrd;
    logic [31:0] sa, sw;
    logic [3:0]  sb;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    // Reset with a store presented.
    rst = 0;
    drive_bubble();
    ctrl_word_in.opcode = op_store; alu_out_in = 32'h40; rs2_in = 32'h1234_5678;
    mem_byte_enable_in = 4'hF; PC_in = 32'h8000_0000; br_en_in = 1;
    @(posedge clk); run_cmp = 1;
    @(posedge clk); #2;
    chk("rst_dmem_write", dmem_write, 0);
    chk("rst_ma_stall", MA_stall, 0);
    chk("rst_alu_out", alu_out_out, 0);
    chk("rst_pc_out", PC_out, 0);
    chk("rst_load_data", load_data_out, 0);
    chk("rst_ctrl_out", 32'(ctrl_word_out), 0);
    chk("rst_br_en", br_en_out, 0);
    drive_bubble();
    rst = 1;
    @(posedge clk); #1;

    // lb / lbu at 0x103.
    mem[8'h40] = 32'h80FF_1234;
    do_op(op_load, 3'b000, 32'h103, 0, 4'h0, 3, 100, 0, ns, nr, nrd, sa, sw, sb);
    chk("lb_stall_cycles", ns, 3);
    chk("lb_addr", sa, 32'h100);
    chk("lb_data", load_data_out, 32'hFFFF_FF80);
    do_op(op_load, 3'b100, 32'h103, 0, 4'h0, 0, 100, 0, ns, nr, nrd, sa, sw, sb);
    chk("lbu_stall_cycles", ns, 0);
    chk("lbu_data", load_data_out, 32'h0000_0080);

    // sh at 0x202.
    do_op(op_store, 3'b001, 32'h202, 32'h0000_BEEF, 4'b1100, 2, 100, 0, ns, nr, nrd, sa, sw, sb);
    chk("sh_wdata", sw, 32'hBEEF_0000);
    chk("sh_be", sb, 4'b1100);
    chk("sh_write_cycles", nr, 3);
    chk("sh_write_dropped", dmem_write, 0);
    chk("sh_mem_upper", mem[8'h80][31:16], 16'hBEEF);

    // lw answered under IF_stall: parked, not re-issued.
    mem[8'hC0] = 32'hDEAD_BEEF;
    do_op(op_load, 3'b010, 32'h300, 0, 4'h0, 1, 1, 4, ns, nr, nrd, sa, sw, sb);
    chk("hold_reissue", nrd, 0);
    chk("hold_req_cycles", nr, 2);
    chk("hold_data", load_data_out, 32'hDEAD_BEEF);

    // Non-memory op.
    do_op(op_reg, 3'b000, 32'h55, 32'h77, 4'h0, 0, 100, 0, ns, nr, nrd, sa, sw, sb);
    chk("add_req", nr, 0);
    chk("add_stall", ns, 0);
    chk("add_alu_out", alu_out_out, 32'h55);
    chk("add_load_data", load_data_out, 0);

    // Reset mid-WAIT, then a stray response.
    ctrl_word_in.opcode = op_load; alu_out_in = 32'h104; instruction_in = 32'h0000_2000;
    @(posedge clk); #1;
    chk("abort_pre_read", dmem_read, 1);
    rst = 0; #1;
    chk("abort_read", dmem_read, 0);
    chk("abort_stall", MA_stall, 0);
    @(posedge clk); #1;
    drive_bubble(); rst = 1;
    @(posedge clk); #1;
    dmem_resp = 1; dmem_rdata = 32'hCAFE_F00D; #1;
    chk("stray_read", dmem_read, 0);
    chk("stray_stall", MA_stall, 0);
    @(posedge clk); #1;
    dmem_resp = 0; #1;
    chk("stray_load", load_data_out, 0);
    chk("stray_alu", alu_out_out, 0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int k;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [3:0]  be;
      rv32i_opcode opc;
      k = $urandom_range(0, 2);
      a = {22'h0, 10'($urandom)};
      be = 4'h0;
      if (k == 0) begin
        opc = op_load;
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
        if (f3 == 3'd2) a[1:0] = 2'b00;
        else if (f3 == 3'd1 || f3 == 3'd5) a[0] = 1'b0;
      end else if (k == 1) begin
        opc = op_store;
        f3 = 3'($urandom_range(0, 2));
        if (f3 == 3'd2) begin a[1:0] = 2'b00; be = 4'hF; end
        else if (f3 == 3'd1) begin a[0] = 1'b0; be = 4'b0011 << a[1:0]; end
        else be = 4'b0001 << a[1:0];
      end else begin
        opc = ($urandom_range(0, 1) == 0) ? op_reg : op_br;
        f3 = 3'($urandom);
      end
      do_op(opc, f3, a, $urandom, be, $urandom_range(0, 3), -1, 0, ns, nr, nrd, sa, sw, sb);
    end

    @(posedge clk); #1;
    run_cmp = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
